// File: rtl/apb_master_ctrl.sv
// APB master engine for the AHB-to-APB bridge: in-order request queue issued as
// SETUP/ACCESS transfers with wait states, PSLVERR, decode errors and an ACCESS timeout.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSLV    = 4,
  parameter int unsigned SEL_LSB = 28,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              wr_err,
  output logic [ADDR_W-1:0] wr_err_addr,
  output logic              idle,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  localparam int unsigned SEL_W    = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNTQ_W   = PTR_W + 1;
  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit          TMO_EN   = (TIMEOUT > 0);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DERR} state_t;

  state_t            state, state_d;
  req_t              mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNTQ_W-1:0] count;
  logic              rd_pending;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              full, push, pop;
  req_t              head, head_nxt, cand;
  logic              cand_avail, cand_derr;
  logic [SEL_W-1:0]  cand_idx;
  logic              tmo_hit, access_done, xfer_tmo, derr_done, complete, cmp_zero, cmp_err;

  logic [ADDR_W-1:0] paddr_d, wr_err_addr_d;
  logic [DATA_W-1:0] pwdata_d, rd_data_d;
  logic [NSLV-1:0]   psel_d;
  logic              pwrite_d, penable_d, rd_valid_d, rd_err_d, wr_err_d;

  assign full      = (count == CNTQ_W'(DEPTH));
  assign req_ready = !full && !rd_pending;
  assign push      = req_valid && req_ready;
  assign idle      = (state == S_IDLE) && (count == '0) && !rd_pending;

  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_ptr + PTR_W'(1)];

  // The entry that would start next: the head from IDLE, the one behind it on a completion.
  always_comb begin
    if (state == S_IDLE) begin
      cand       = head;
      cand_avail = (count != '0);
    end else begin
      cand       = head_nxt;
      cand_avail = (count > CNTQ_W'(1));
    end
  end

  assign cand_idx  = cand.addr[SEL_LSB +: SEL_W];
  assign cand_derr = (32'(cand_idx) >= NSLV);

  assign tmo_hit     = TMO_EN && (tmo_cnt == CNT_W'(TMO_LAST));
  assign access_done = (state == S_ACCESS) && (pready || tmo_hit);
  assign xfer_tmo    = (state == S_ACCESS) && !pready && tmo_hit;
  assign derr_done   = (state == S_DERR);
  assign complete    = access_done || derr_done;
  assign pop         = complete;
  assign cmp_zero    = xfer_tmo || derr_done;
  assign cmp_err     = cmp_zero || (access_done && pready && pslverr);

  // State register
  always_ff @(posedge hclk) begin
    if (hreset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (cand_avail) state_d = cand_derr ? S_DERR : S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (access_done) state_d = !cand_avail ? S_IDLE : (cand_derr ? S_DERR : S_SETUP);
      S_DERR:   state_d = !cand_avail ? S_IDLE : (cand_derr ? S_DERR : S_SETUP);
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered APB and completion outputs
  always_comb begin
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    pwrite_d      = pwrite;
    psel_d        = psel;
    penable_d     = 1'b0;
    rd_valid_d    = 1'b0;
    rd_err_d      = rd_err;
    rd_data_d     = rd_data;
    wr_err_d      = 1'b0;
    wr_err_addr_d = wr_err_addr;
    unique case (state_d)
      S_SETUP: begin
        paddr_d  = cand.addr;
        pwdata_d = cand.wdata;
        pwrite_d = cand.write;
        psel_d   = NSLV'(1) << cand_idx;
      end
      S_ACCESS: penable_d = 1'b1;
      default:  psel_d = '0;
    endcase
    if (complete && !head.write) begin
      rd_valid_d = 1'b1;
      rd_err_d   = cmp_err;
      rd_data_d  = cmp_zero ? '0 : prdata;
    end
    if (complete && head.write && cmp_err) begin
      wr_err_d      = 1'b1;
      wr_err_addr_d = head.addr;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      paddr       <= '0;
      pwdata      <= '0;
      pwrite      <= 1'b0;
      psel        <= '0;
      penable     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_err      <= 1'b0;
      rd_data     <= '0;
      wr_err      <= 1'b0;
      wr_err_addr <= '0;
    end else begin
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      pwrite      <= pwrite_d;
      psel        <= psel_d;
      penable     <= penable_d;
      rd_valid    <= rd_valid_d;
      rd_err      <= rd_err_d;
      rd_data     <= rd_data_d;
      wr_err      <= wr_err_d;
      wr_err_addr <= wr_err_addr_d;
    end
  end

  // Queue pointers, read tracking and ACCESS-cycle counter
  always_ff @(posedge hclk) begin
    if (hreset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNTQ_W'(1);
        2'b01:   count <= count - CNTQ_W'(1);
        default: count <= count;
      endcase
      // Held through the rd_valid cycle so a new request waits for the completion to be seen.
      if (push && !req_write) rd_pending <= 1'b1;
      else if (rd_valid)      rd_pending <= 1'b0;
      if (state == S_ACCESS && state_d == S_ACCESS) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                                          tmo_cnt <= '0;
    end
  end

  // Queue storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge hclk) begin
    if (push) mem[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
  end

endmodule
